// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: drives p_ctrl of every pipeline register plus PC hold.
// Optional performance counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_hold,
   output logic [1:0]       if_id_ctrl,
   output logic [1:0]       id_ex_ctrl,
   output logic [1:0]       ex_mem_ctrl,
   output logic [1:0]       mem_wb_ctrl,
   output logic             mem_fault,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt,
   output logic [1:0]       fsm_state
);

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1 || CNT_W > 2 * XLEN) begin : g_param_check
      $error("pipe_hazard_ctrl: illegal MEM_TIMEOUT or CNT_W");
   end

   // p_ctrl encoding: [0] hold, [1] flush-to-zero
   localparam logic [1:0] C_PASS  = 2'b00;
   localparam logic [1:0] C_HOLD  = 2'b01;
   localparam logic [1:0] C_FLUSH = 2'b10;
   localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RST   = 2'd0,
      RUN   = 2'd1,
      MWAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] wait_cnt;
   logic        mstall, mem_hold, mwait_done, timeout, load_use, redir_sel;

   assign mstall = dmem_req & ~dmem_ready;

   // wait_cnt holds the number of cycles elapsed since the first stalled cycle
   assign timeout    = (state_q == MWAIT) & ~dmem_ready & (wait_cnt == TIMEOUT);
   assign mwait_done = dmem_ready | timeout;
   assign mem_hold   = ((state_q == RUN) & mstall) | ((state_q == MWAIT) & ~dmem_ready);

   assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= RST;
         wait_cnt <= 16'd0;
      end else begin
         state_q <= state_d;
         if (state_q == RUN && mstall)
            wait_cnt <= 16'd1;
         else if (state_q == MWAIT && !mwait_done)
            wait_cnt <= wait_cnt + 16'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RST:     state_d = RUN;
         RUN:     if (mstall) state_d = MWAIT;
         MWAIT:   if (mwait_done) state_d = RUN;
         default: state_d = RST;
      endcase
   end

   always_comb begin
      pc_hold     = 1'b0;
      if_id_ctrl  = C_PASS;
      id_ex_ctrl  = C_PASS;
      ex_mem_ctrl = C_PASS;
      mem_wb_ctrl = C_PASS;
      mem_fault   = 1'b0;
      redir_sel   = 1'b0;
      if (state_q == RST) begin
         pc_hold     = 1'b1;
         if_id_ctrl  = C_FLUSH;
         id_ex_ctrl  = C_FLUSH;
         ex_mem_ctrl = C_FLUSH;
         mem_wb_ctrl = C_FLUSH;
      end else if (mem_hold) begin
         // the timeout cycle keeps the stall pattern; mem_wb flush drops the faulting access
         pc_hold     = 1'b1;
         if_id_ctrl  = C_HOLD;
         id_ex_ctrl  = C_HOLD;
         ex_mem_ctrl = C_HOLD;
         mem_wb_ctrl = C_FLUSH;
         mem_fault   = timeout;
      end else if (ex_redirect) begin
         redir_sel  = 1'b1;
         if_id_ctrl = C_FLUSH;
         id_ex_ctrl = C_FLUSH;
      end else if (load_use) begin
         pc_hold    = 1'b1;
         if_id_ctrl = C_HOLD;
         id_ex_ctrl = C_FLUSH;
      end else if (!imem_ready) begin
         pc_hold    = 1'b1;
         if_id_ctrl = C_FLUSH;
      end
   end

   assign fsm_state = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (pc_hold && state_q != RST) stall_q <= stall_q + CNT_ONE;
         if (redir_sel) flush_q <= flush_q + CNT_ONE;
      end
   end

   assign perf_stall_cnt = stall_q;
   assign perf_flush_cnt = flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a default-timeout instance (a) and a MEM_TIMEOUT=3 instance (b) share stimulus.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 32;

   // packed expectation: {pc_hold, if_id, id_ex, ex_mem, mem_wb, mem_fault}
   localparam logic [9:0] P_RST  = 10'b1_10_10_10_10_0;
   localparam logic [9:0] P_IDLE = 10'b0_00_00_00_00_0;
   localparam logic [9:0] P_MS   = 10'b1_01_01_01_10_0;
   localparam logic [9:0] P_FLT  = 10'b1_01_01_01_10_1;
   localparam logic [9:0] P_RD   = 10'b0_10_10_00_00_0;
   localparam logic [9:0] P_LU   = 10'b1_01_10_00_00_0;
   localparam logic [9:0] P_FW   = 10'b1_10_00_00_00_0;

   logic clock = 1'b0;
   logic reset_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_req, dmem_ready;

   logic pc_hold_a, mem_fault_a, pc_hold_b, mem_fault_b;
   logic [1:0] if_id_a, id_ex_a, ex_mem_a, mem_wb_a, state_a;
   logic [1:0] if_id_b, id_ex_b, ex_mem_b, mem_wb_b, state_b;
   logic [CNT_W-1:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

   logic [19:0] exp_q[$];
   string       tag_q[$];
   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [31:0] exp_stall = 0;
   logic [31:0] exp_flush = 0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   pipe_hazard_ctrl #(.XLEN(32), .MEM_TIMEOUT(255), .CNT_W(CNT_W)) dut_a (
      .clock(clock), .reset_n(reset_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_hold(pc_hold_a), .if_id_ctrl(if_id_a), .id_ex_ctrl(id_ex_a),
      .ex_mem_ctrl(ex_mem_a), .mem_wb_ctrl(mem_wb_a), .mem_fault(mem_fault_a),
      .perf_stall_cnt(stall_cnt_a), .perf_flush_cnt(flush_cnt_a), .fsm_state(state_a)
   );

   pipe_hazard_ctrl #(.XLEN(32), .MEM_TIMEOUT(3), .CNT_W(CNT_W)) dut_b (
      .clock(clock), .reset_n(reset_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_hold(pc_hold_b), .if_id_ctrl(if_id_b), .id_ex_ctrl(id_ex_b),
      .ex_mem_ctrl(ex_mem_b), .mem_wb_ctrl(mem_wb_b), .mem_fault(mem_fault_b),
      .perf_stall_cnt(stall_cnt_b), .perf_flush_cnt(flush_cnt_b), .fsm_state(state_b)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- driver ----------------
   task automatic step(input string tag, input logic rst_v,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic rdr, input logic imr,
                       input logic dreq, input logic drdy,
                       input logic [9:0] ea, input logic [9:0] eb);
      reset_n     = rst_v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      ex_rd       = rd;
      ex_mem_read = mr;
      ex_redirect = rdr;
      imem_ready  = imr;
      dmem_req    = dreq;
      dmem_ready  = drdy;
      exp_q.push_back({ea, eb});
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clock) begin
      logic [19:0] e;
      string       t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check({t, "_a"}, {22'd0, pc_hold_a, if_id_a, id_ex_a, ex_mem_a, mem_wb_a, mem_fault_a}, {22'd0, e[19:10]});
         check({t, "_b"}, {22'd0, pc_hold_b, if_id_b, id_ex_b, ex_mem_b, mem_wb_b, mem_fault_b}, {22'd0, e[9:0]});
`ifdef PIPE_HAZARD_CTRL_PERF_EN
         check({t, "_stall_cnt"}, stall_cnt_a, exp_stall);
         check({t, "_flush_cnt"}, flush_cnt_a, exp_flush);
         if (!reset_n) begin
            exp_stall = 0;
            exp_flush = 0;
         end else begin
            if (e[19] && e[19:10] != P_RST) exp_stall = exp_stall + 1;
            if (e[19:10] == P_RD) exp_flush = exp_flush + 1;
         end
`else
         check({t, "_stall_cnt"}, stall_cnt_a, 32'd0);
         check({t, "_flush_cnt"}, flush_cnt_a, 32'd0);
`endif
      end
   end

   // ---------------- stimulus ----------------
   // step args: tag, reset_n, rs1, rs2, use1, use2, ex_rd, mem_read, redirect, imem_ready, dmem_req, dmem_ready, exp_a, exp_b
   initial begin
      reset_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0; ex_redirect = 1'b0; imem_ready = 1'b1;
      dmem_req = 1'b0; dmem_ready = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) step("rst_low", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_RST, P_RST);
      step("rst_rel",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_RST,  P_RST);
      step("idle",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_IDLE, P_IDLE);
      step("lu_rs2",    1, 3, 5, 1, 1, 5, 1, 0, 1, 0, 0, P_LU,   P_LU);
      step("after_lu",  1, 3, 5, 1, 1, 9, 0, 0, 1, 0, 0, P_IDLE, P_IDLE);
      step("lu_x0",     1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, P_IDLE, P_IDLE);
      step("lu_nouse",  1, 7, 2, 0, 1, 7, 1, 0, 1, 0, 0, P_IDLE, P_IDLE);
      step("lu_noload", 1, 7, 2, 1, 1, 7, 0, 0, 1, 0, 0, P_IDLE, P_IDLE);
      step("lu_rs1",    1, 7, 2, 1, 0, 7, 1, 0, 1, 0, 0, P_LU,   P_LU);
      step("rd_lu",     1, 7, 2, 1, 0, 7, 1, 1, 1, 0, 0, P_RD,   P_RD);
      step("rd_fw",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, P_RD,   P_RD);
      step("fetch_w",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_FW,   P_FW);
      step("lu_fw",     1, 4, 0, 1, 0, 4, 1, 0, 0, 0, 0, P_LU,   P_LU);
      // 4-cycle dmem wait; b times out on the 4th stalled cycle
      for (int i = 0; i < 3; i++) step("dwait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS, P_MS);
      step("dwait4",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS,   P_FLT);
      step("dwait_ok",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_IDLE, P_IDLE);
      // ready on the timeout cycle wins
      for (int i = 0; i < 3; i++) step("tsame", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS, P_MS);
      step("tsame_rdy", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_IDLE, P_IDLE);
      // plain timeout, then stall release on b
      for (int i = 0; i < 3; i++) step("tout", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS, P_MS);
      step("tout_flt",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS,   P_FLT);
      step("tout_rel",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_MS,   P_IDLE);
      step("tout_a_ok", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, P_IDLE, P_IDLE);
      // fetch wait and redirect under a dmem stall
      step("fw_ms",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_MS,   P_MS);
      step("rd_ms",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, P_MS,   P_MS);
      step("ms_done",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_IDLE, P_IDLE);
      // reset in the middle of a wait clears the counter
      step("rm1",       1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS,   P_MS);
      step("rm2",       1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS,   P_MS);
      step("rm_rst",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS,   P_MS);
      step("rm_inrst",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_RST,  P_RST);
      step("rm_rel",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_RST,  P_RST);
      step("rm_idle",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_IDLE, P_IDLE);
      for (int i = 0; i < 3; i++) step("rc", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS, P_MS);
      step("rc_flt",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_MS,   P_FLT);
      step("rc_done",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_IDLE, P_IDLE);
      // random idle-ish traffic with no hazards at all
      for (int i = 0; i < 20; i++) begin
         logic [4:0] r;
         r = 5'($urandom_range(1, 31));
         step("rand_nohaz", 1, r, r, 1, 1, r, 0, 0, 1, $urandom_range(0, 1) == 1, 1, P_IDLE, P_IDLE);
      end
      @(negedge clock);
      check("queue_drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
